// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, key-length encodings and the small
// lookup functions (Nk, Nr, Rcon) used by the expander.
package aes_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    OUTPUT
  } state_t;

  localparam logic [1:0] KEY_LEN_128     = 2'd0;
  localparam logic [1:0] KEY_LEN_192     = 2'd1;
  localparam logic [1:0] KEY_LEN_256     = 2'd2;
  localparam logic [1:0] KEY_LEN_ILLEGAL = 2'd3;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KEY_LEN_128: nk_of = 4'd4;
      KEY_LEN_192: nk_of = 4'd6;
      KEY_LEN_256: nk_of = 4'd8;
      default:     nk_of = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KEY_LEN_128: nr_of = 4'd10;
      KEY_LEN_192: nr_of = 4'd12;
      KEY_LEN_256: nr_of = 4'd14;
      default:     nr_of = 4'd0;
    endcase
  endfunction

  function automatic word_t rcon(input logic [3:0] j);
    case (j)
      4'd1:    rcon = 32'h01000000;
      4'd2:    rcon = 32'h02000000;
      4'd3:    rcon = 32'h04000000;
      4'd4:    rcon = 32'h08000000;
      4'd5:    rcon = 32'h10000000;
      4'd6:    rcon = 32'h20000000;
      4'd7:    rcon = 32'h40000000;
      4'd8:    rcon = 32'h80000000;
      4'd9:    rcon = 32'h1b000000;
      4'd10:   rcon = 32'h36000000;
      default: rcon = 32'h00000000;
    endcase
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  word_t word_i,
  output word_t word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sbox u_sbox (
      .in_i  (word_i[8*b +: 8]),
      .out_o (word_o[8*b +: 8])
    );
  end

endmodule

// File: rtl/sbox.sv
// AES forward S-box as a flat constant table; byte 0 sits in the top 8 bits.
module sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry n lives at bit offset (255-n)*8, and 255-n is simply ~n.
  assign out_o = SBOX_TABLE[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule: expands one word per cycle into a
// register buffer, then streams 128-bit round keys forward or in reverse.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic                    inverse,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  output logic                    busy,
  output logic                    err,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [127:0]            rk_data,
  output logic [3:0]              rk_idx,
  output logic                    rk_last
);

  localparam int NK_MAX = MAX_KEY_BITS / 32;
  localparam int NR_MAX = NK_MAX + 6;
  localparam int NW_MAX = 4 * (NR_MAX + 1);

  state_t     state_q, state_d;
  logic [3:0] nk_q, nk_d, nr_q, nr_d, j_q, j_d, r_q, r_d;
  logic [2:0] m_q, m_d;
  logic [5:0] i_q, i_d;
  logic       inv_q, inv_d, err_q, err_d;
  word_t      w_q [NW_MAX];

  logic       legal, accept, expandDone, lastKey;
  logic [5:0] nwLast, rkBase;
  word_t      prevWord, backWord, subIn, subOut, tWord, newWord;

  assign legal      = (key_len != KEY_LEN_ILLEGAL) &&
                      (32 * int'(nk_of(key_len)) <= MAX_KEY_BITS);
  assign accept     = (state_q == IDLE) && start && legal;
  assign nwLast     = {nr_q, 2'b11};
  assign expandDone = (i_q == nwLast);
  assign lastKey    = inv_q ? (r_q == 4'd0) : (r_q == nr_q);
  assign rkBase     = {r_q, 2'b00};

  // m_q tracks i mod Nk and j_q tracks i/Nk, avoiding a divide by six.
  assign prevWord = w_q[i_q - 6'd1];
  assign backWord = w_q[i_q - {2'b00, nk_q}];
  assign subIn    = (m_q == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;

  aes_subword u_subword (
    .word_i (subIn),
    .word_o (subOut)
  );

  always_comb begin
    if (m_q == 3'd0)                        tWord = subOut ^ rcon(j_q);
    else if (nk_q == 4'd8 && m_q == 3'd4)   tWord = subOut;
    else                                    tWord = prevWord;
  end

  assign newWord = backWord ^ tWord;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXPAND;
      EXPAND:  if (expandDone) state_d = OUTPUT;
      OUTPUT:  if (rk_ready && lastKey) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    err      = err_q;
    rk_valid = (state_q == OUTPUT);
    rk_data  = '0;
    rk_idx   = '0;
    rk_last  = 1'b0;
    if (state_q == OUTPUT) begin
      rk_data = {w_q[rkBase], w_q[rkBase + 6'd1], w_q[rkBase + 6'd2], w_q[rkBase + 6'd3]};
      rk_idx  = r_q;
      rk_last = lastKey;
    end
  end

  always_comb begin
    nk_d  = nk_q;
    nr_d  = nr_q;
    inv_d = inv_q;
    i_d   = i_q;
    m_d   = m_q;
    j_d   = j_q;
    r_d   = r_q;
    err_d = (state_q == IDLE) && start && !legal;
    case (state_q)
      IDLE: if (accept) begin
        nk_d  = nk_of(key_len);
        nr_d  = nr_of(key_len);
        inv_d = inverse;
        i_d   = {2'b00, nk_of(key_len)};
        m_d   = 3'd0;
        j_d   = 4'd1;
        r_d   = inverse ? nr_of(key_len) : 4'd0;
      end
      EXPAND: begin
        i_d = expandDone ? i_q : i_q + 6'd1;
        if ({1'b0, m_q} == nk_q - 4'd1) begin
          m_d = 3'd0;
          j_d = (j_q == 4'hF) ? j_q : j_q + 4'd1;
        end else begin
          m_d = m_q + 3'd1;
        end
      end
      OUTPUT: if (rk_ready && !lastKey) r_d = inv_q ? r_q - 4'd1 : r_q + 4'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nk_q  <= '0;
      nr_q  <= '0;
      inv_q <= 1'b0;
      i_q   <= '0;
      m_q   <= '0;
      j_q   <= '0;
      r_q   <= '0;
      err_q <= 1'b0;
    end else begin
      nk_q  <= nk_d;
      nr_q  <= nr_d;
      inv_q <= inv_d;
      i_q   <= i_d;
      m_q   <= m_d;
      j_q   <= j_d;
      r_q   <= r_d;
      err_q <= err_d;
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NK_MAX; k++) begin
        if (4'(k) < nk_of(key_len)) w_q[k] <= key_in[MAX_KEY_BITS-1-32*k -: 32];
      end
    end else if (state_q == EXPAND) begin
      w_q[i_q] <= newWord;
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed self-checking bench for aes_key_expander using FIPS-197 key vectors.
module tb_aes_key_expander;

  localparam logic [255:0] K128     = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK128_2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K192     = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] RK192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [255:0] K256     = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] RK256_3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
  localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic         inverse = 1'b0;
  logic [255:0] key_in = '0;
  logic         rk_ready = 1'b1;
  logic         busy, err, rk_valid, rk_last;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  logic         start128 = 1'b0;
  logic [1:0]   key_len128 = 2'd0;
  logic [127:0] key_in128 = '0;
  logic         busy128, err128, rk_valid128, rk_last128;
  logic [127:0] rk_data128;
  logic [3:0]   rk_idx128;

  int           errors = 0;
  int           checks = 0;
  logic [127:0] seenData [15];
  logic         seenLast [15];
  int           order [15];
  int           seenCount [15];
  int           firstCyc;

  aes_key_expander #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .inverse(inverse),
    .key_in(key_in), .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  aes_key_expander #(.MAX_KEY_BITS(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(start128), .key_len(key_len128), .inverse(1'b0),
    .key_in(key_in128), .busy(busy128), .err(err128), .rk_valid(rk_valid128), .rk_ready(1'b1),
    .rk_data(rk_data128), .rk_idx(rk_idx128), .rk_last(rk_last128)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic launchNow(input logic [1:0] kl, input logic inv, input logic [255:0] key);
    start = 1'b1; key_len = kl; inverse = inv; key_in = key;
    @(posedge clk); #1;
    start = 1'b0; key_len = 2'd0; inverse = 1'b0; key_in = '0;
  endtask

  task automatic applyStimulus(input logic [1:0] kl, input logic inv, input logic [255:0] key);
    @(negedge clk);
    launchNow(kl, inv, key);
  endtask

  task automatic clearSeen();
    for (int k = 0; k < 15; k++) begin
      seenData[k] = '0; seenLast[k] = 1'b0; order[k] = -1; seenCount[k] = 0;
    end
  endtask

  // Cycle 1 is the first cycle after the acceptance edge.
  task automatic collectKeys(input int total);
    int cyc = 0;
    int got = 0;
    firstCyc = -1;
    clearSeen();
    rk_ready = 1'b1;
    while (got < total && cyc < 200) begin
      @(negedge clk); cyc++;
      if (rk_valid) begin
        if (firstCyc < 0) firstCyc = cyc;
        seenData[rk_idx] = rk_data;
        seenLast[rk_idx] = rk_last;
        order[got] = int'(rk_idx);
        got++;
      end
    end
    checkOutput("keyCount", got, total);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [133:0] holdVal;
    logic         holdPending;
    logic         anyValid;
    int           cyc, got;

    #1 rst_n = 1'b0;
    #11;
    checkOutput("resetState", {busy, err, rk_valid, rk_data, rk_idx, rk_last}, '0);
    checkOutput("resetState128", {busy128, err128, rk_valid128, rk_data128, rk_idx128, rk_last128}, '0);
    @(negedge clk); rst_n = 1'b1;

    $display("[TB] AES-128 forward");
    applyStimulus(2'd0, 1'b0, K128);
    collectKeys(11);
    checkOutput("aes128FirstValid", firstCyc, 41);
    checkOutput("aes128Rk0", seenData[0], K128[255:128]);
    checkOutput("aes128Rk1", seenData[1], RK128_1);
    checkOutput("aes128Rk2", seenData[2], RK128_2);
    checkOutput("aes128Rk10", seenData[10], RK128_10);
    checkOutput("aes128Last10", seenLast[10], 1);
    checkOutput("aes128Last9", seenLast[9], 0);
    for (int k = 0; k < 11; k++) checkOutput($sformatf("aes128Order%0d", k), order[k], k);
    @(negedge clk);
    checkOutput("aes128BusyFall", busy, 0);

    $display("[TB] AES-192 inverse");
    applyStimulus(2'd1, 1'b1, K192);
    collectKeys(13);
    checkOutput("aes192FirstValid", firstCyc, 47);
    checkOutput("aes192Rk12", seenData[12], RK192_12);
    checkOutput("aes192Rk0", seenData[0], RK192_0);
    checkOutput("aes192Last0", seenLast[0], 1);
    checkOutput("aes192Last12", seenLast[12], 0);
    for (int k = 0; k < 13; k++) checkOutput($sformatf("aes192Order%0d", k), order[k], 12 - k);
    @(negedge clk);
    checkOutput("aes192BusyFall", busy, 0);

    $display("[TB] AES-256 forward, started back-to-back");
    launchNow(2'd2, 1'b0, K256);
    collectKeys(15);
    checkOutput("aes256FirstValid", firstCyc, 53);
    checkOutput("aes256Rk2", seenData[2], RK256_2);
    checkOutput("aes256Rk3", seenData[3], RK256_3);
    checkOutput("aes256Rk14", seenData[14], RK256_14);
    checkOutput("aes256Last14", seenLast[14], 1);
    @(negedge clk);
    checkOutput("aes256BusyFall", busy, 0);

    $display("[TB] illegal key lengths");
    start = 1'b1; key_len = 2'd3; start128 = 1'b1; key_len128 = 2'd2;
    @(posedge clk); #1;
    start = 1'b0; key_len = 2'd0; start128 = 1'b0; key_len128 = 2'd0;
    @(negedge clk);
    checkOutput("errLen3", err, 1);
    checkOutput("errLen3Busy", busy, 0);
    checkOutput("errUnsupported", err128, 1);
    checkOutput("errUnsupportedBusy", busy128, 0);
    @(negedge clk);
    checkOutput("errLen3Pulse", err, 0);
    checkOutput("errUnsupportedPulse", err128, 0);

    $display("[TB] AES-128 with random stalls");
    applyStimulus(2'd0, 1'b0, K128);
    clearSeen();
    holdPending = 1'b0; holdVal = '0; cyc = 0; got = 0;
    while (got < 11 && cyc < 600) begin
      @(negedge clk); cyc++;
      start = 1'b0;
      if (holdPending) checkOutput("stallHold", {rk_valid, rk_idx, rk_last, rk_data}, holdVal);
      checkOutput("stallNoErr", err, 0);
      rk_ready = 1'($urandom_range(0, 1));
      holdPending = 1'b0;
      if (rk_valid && rk_ready) begin
        seenCount[rk_idx]++;
        seenData[rk_idx] = rk_data;
        seenLast[rk_idx] = rk_last;
        got++;
      end else if (rk_valid) begin
        holdPending = 1'b1;
        holdVal = {rk_valid, rk_idx, rk_last, rk_data};
      end
      if (!(rk_valid && rk_ready && rk_last) && (cyc % 5 == 2)) begin
        start = 1'b1;
        key_len = (cyc % 2 == 1) ? 2'd3 : 2'd2;
        key_in = K256;
      end
    end
    start = 1'b0; key_len = 2'd0; key_in = '0; rk_ready = 1'b1;
    checkOutput("stallKeyCount", got, 11);
    for (int k = 0; k < 11; k++) checkOutput($sformatf("stallSeen%0d", k), seenCount[k], 1);
    checkOutput("stallRk1", seenData[1], RK128_1);
    checkOutput("stallRk10", seenData[10], RK128_10);
    checkOutput("stallLast10", seenLast[10], 1);
    @(negedge clk);
    checkOutput("stallBusyFall", busy, 0);

    $display("[TB] reset during expansion");
    applyStimulus(2'd2, 1'b0, K256);
    repeat (19) @(negedge clk);
    @(posedge clk); #2;
    checkOutput("busyBeforeReset", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncReset", {busy, err, rk_valid, rk_data, rk_idx, rk_last}, '0);
    #20;
    @(negedge clk); rst_n = 1'b1;
    anyValid = 1'b0;
    repeat (80) begin
      @(negedge clk);
      anyValid = anyValid | rk_valid | busy;
    end
    checkOutput("quietAfterReset", anyValid, 0);
    applyStimulus(2'd0, 1'b0, K128);
    collectKeys(11);
    checkOutput("postResetFirstValid", firstCyc, 41);
    checkOutput("postResetRk1", seenData[1], RK128_1);
    checkOutput("postResetRk10", seenData[10], RK128_10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
